skolem_sweep_checker: RTL and testbench

- Sequential exhaustive-sweep harness placed directly upstream of a generated combinational Skolem function block (N_IN inputs, N_OUT outputs).
- Drives every input assignment 0 .. 2^N_IN-1 into the Skolem block and samples the Skolem outputs LAT cycles later.
- Samples a spec-formula evaluator's verdict for the same vector.
- Reports pass/fail, a failure count and the first failing vector.

---
 rtl/skolem_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_skolem_sweep_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_sweep_checker.sv
// rtl/skolem_sweep_checker.sv - exhaustive input sweep and verdict checker for a combinational Skolem block
// Optional MISR signature over y_i is enabled by defining SKOLEM_SWEEP_MISR_EN.
module skolem_sweep_checker #(
    parameter int N_IN             = 8,
    parameter int N_OUT            = 1,
    parameter int LAT              = 1,
    parameter int SIG_W            = 16,
    parameter logic [SIG_W-1:0] SIG_POLY = 16'hB400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    output logic [N_IN-1:0]   x_o,
    output logic              x_valid_o,
    input  logic [N_OUT-1:0]  y_i,
    input  logic              spec_ok_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [N_IN:0]     fail_cnt_o,
    output logic              first_fail_vld_o,
    output logic [N_IN-1:0]   first_fail_x_o,
    output logic [N_OUT-1:0]  first_fail_y_o
`ifdef SKOLEM_SWEEP_MISR_EN
    ,
    input  logic [SIG_W-1:0]  exp_sig_i,
    output logic [SIG_W-1:0]  sig_o
`endif
);

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t          state, state_nx;
    logic [CW-1:0]   drain_cnt;
    logic [LAT-1:0]  pipe_v;
    logic [N_IN-1:0] pipe_x [LAT];

    logic            tap_v;
    logic [N_IN-1:0] tap_x;
    logic            check_fail;
    logic            last_x;
    logic            start_go;
    logic            drain_end;
    logic            sig_ok;
    logic            pass_nx;

    assign tap_v      = pipe_v[LAT-1];
    assign tap_x      = pipe_x[LAT-1];
    assign check_fail = tap_v && !spec_ok_i;
    assign last_x     = (x_o == {N_IN{1'b1}});
    assign start_go   = (state == IDLE || state == DONE) && start_i && !abort_i;
    assign drain_end  = (state == DRAIN) && (drain_cnt == CW'(LAT - 1));
    assign busy_o     = (state == DRIVE) || (state == DRAIN);

`ifdef SKOLEM_SWEEP_MISR_EN
    logic [SIG_W-1:0] sig_nx;
    assign sig_nx = {sig_o[SIG_W-2:0], 1'b0} ^ (sig_o[SIG_W-1] ? SIG_POLY : '0) ^ SIG_W'(y_i);
    assign sig_ok = (sig_nx == exp_sig_i);
`else
    assign sig_ok = 1'b1;
`endif

    // The last vector is checked on the same edge that leaves DRAIN, so its verdict folds in here.
    assign pass_nx = (fail_cnt_o == '0) && !check_fail && sig_ok;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start_i) state_nx = DRIVE;
            DRIVE:      if (last_x) state_nx = DRAIN;
            DRAIN:      if (drain_end) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
        if (abort_i) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            x_o              <= '0;
            x_valid_o        <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
            fail_cnt_o       <= '0;
            first_fail_vld_o <= 1'b0;
            first_fail_x_o   <= '0;
            first_fail_y_o   <= '0;
            drain_cnt        <= '0;
            pipe_v           <= '0;
            for (int i = 0; i < LAT; i++) pipe_x[i] <= '0;
`ifdef SKOLEM_SWEEP_MISR_EN
            sig_o            <= '0;
`endif
        end else begin
            state     <= state_nx;
            done_o    <= 1'b0;
            pipe_v[0] <= x_valid_o;
            pipe_x[0] <= x_o;
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_x[i] <= pipe_x[i-1];
            end
            if (abort_i) begin
                x_valid_o <= 1'b0;
                pipe_v    <= '0;
                pass_o    <= 1'b0;
            end else if (start_go) begin
                x_o              <= '0;
                x_valid_o        <= 1'b1;
                pass_o           <= 1'b0;
                fail_cnt_o       <= '0;
                first_fail_vld_o <= 1'b0;
                first_fail_x_o   <= '0;
                first_fail_y_o   <= '0;
`ifdef SKOLEM_SWEEP_MISR_EN
                sig_o            <= '0;
`endif
            end else begin
                if (state == DRIVE) begin
                    drain_cnt <= '0;
                    if (last_x) x_valid_o <= 1'b0;
                    else        x_o <= x_o + N_IN'(1);
                end
                if (state == DRAIN) begin
                    drain_cnt <= drain_cnt + CW'(1);
                    if (drain_end) begin
                        done_o <= 1'b1;
                        pass_o <= pass_nx;
                    end
                end
                if (check_fail) begin
                    fail_cnt_o <= fail_cnt_o + (N_IN+1)'(1);
                    if (!first_fail_vld_o) begin
                        first_fail_vld_o <= 1'b1;
                        first_fail_x_o   <= tap_x;
                        first_fail_y_o   <= y_i;
                    end
                end
`ifdef SKOLEM_SWEEP_MISR_EN
                if (tap_v) sig_o <= sig_nx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// tb/tb_skolem_sweep_checker.sv - directed self-checking bench for skolem_sweep_checker
module tb_skolem_sweep_checker;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode_a = 0;
    int mode_b = 0;

    logic       start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [7:0] x_a, x_b, ffx_a, ffx_b;
    logic       xv_a, xv_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
    logic [8:0] fcnt_a, fcnt_b;
    logic       ffv_a, ffv_b;
    logic [0:0] ffy_a, ffy_b, y_a, y_b;
    logic       ok_a, ok_b;
    logic [7:0] xa1 = '0, xb1 = '0, xb2 = '0, xb3 = '0;

    function automatic logic ok_fn(int m, logic [7:0] x);
        case (m)
            1:       return !(x == 8'h2C || x == 8'hF1);
            2:       return x != 8'd40;
            3:       return x != 8'hFF;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic y_fn(int m, logic [7:0] x);
        case (m)
            1:       return 1'b1;
            4:       return x[0];
            default: return 1'b0;
        endcase
    endfunction

    // Skolem block + evaluator models: LAT-stage delay of x_o feeding pure functions.
    always @(posedge clk) begin
        xa1 <= x_a;
        xb1 <= x_b;
        xb2 <= xb1;
        xb3 <= xb2;
    end
    assign y_a  = y_fn(mode_a, xa1);
    assign ok_a = ok_fn(mode_a, xa1);
    assign y_b  = y_fn(mode_b, xb3);
    assign ok_b = ok_fn(mode_b, xb3);

`ifdef SKOLEM_SWEEP_MISR_EN
    logic [15:0] exp_sig_a = '0;
    logic [15:0] sig_a, sig_b;
`endif

    skolem_sweep_checker #(.N_IN(8), .N_OUT(1), .LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
        .x_o(x_a), .x_valid_o(xv_a), .y_i(y_a), .spec_ok_i(ok_a),
        .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .fail_cnt_o(fcnt_a),
        .first_fail_vld_o(ffv_a), .first_fail_x_o(ffx_a), .first_fail_y_o(ffy_a)
`ifdef SKOLEM_SWEEP_MISR_EN
        , .exp_sig_i(exp_sig_a), .sig_o(sig_a)
`endif
    );

    skolem_sweep_checker #(.N_IN(8), .N_OUT(1), .LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
        .x_o(x_b), .x_valid_o(xv_b), .y_i(y_b), .spec_ok_i(ok_b),
        .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .fail_cnt_o(fcnt_b),
        .first_fail_vld_o(ffv_b), .first_fail_x_o(ffx_b), .first_fail_y_o(ffy_b)
`ifdef SKOLEM_SWEEP_MISR_EN
        , .exp_sig_i(16'h0000), .sig_o(sig_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse(input int which);
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Called right after start_pulse; sample n is taken #1 after edge n (edge 0 sampled start_i).
    task automatic wait_done(input int which, output int done_at, output int seq_err);
        int n = 0;
        seq_err = 0;
        while (n < 2000) begin
            if (which == 0) begin
                if (xv_a && (32'(x_a) != n)) seq_err++;
                if (done_a) break;
            end else begin
                if (xv_b && (32'(x_b) != n)) seq_err++;
                if (done_b) break;
            end
            @(posedge clk); #1;
            n++;
        end
        done_at = (n < 2000) ? n : -1;
    endtask

    int done_at, seq_err, cnt;
    logic [15:0] model_sig;

    initial begin
        #12;
        chk("rst_x", 32'(x_a), 0);
        chk("rst_xvalid", 32'(xv_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_pass", 32'(pass_a), 0);
        chk("rst_fcnt", 32'(fcnt_a), 0);
        chk("rst_ffv", 32'(ffv_a), 0);
        chk("rst_ffx", 32'(ffx_a), 0);
        chk("rst_ffy", 32'(ffy_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // clean sweep, LAT=1
        mode_a = 0;
        start_pulse(0);
        chk("t1_first_x", 32'(x_a), 0);
        chk("t1_first_valid", 32'(xv_a), 1);
        wait_done(0, done_at, seq_err);
        chk("t1_done_at", 32'(done_at), 257);
        chk("t1_seq", 32'(seq_err), 0);
        chk("t1_pass", 32'(pass_a), 1);
        chk("t1_fcnt", 32'(fcnt_a), 0);
        chk("t1_ffv", 32'(ffv_a), 0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done_a), 0);
        chk("t1_busy_after", 32'(busy_a), 0);
        chk("t1_pass_held", 32'(pass_a), 1);

        // two failures, restart from DONE
        mode_a = 1;
        start_pulse(0);
        chk("t2_cleared_pass", 32'(pass_a), 0);
        wait_done(0, done_at, seq_err);
        chk("t2_done_at", 32'(done_at), 257);
        chk("t2_fcnt", 32'(fcnt_a), 2);
        chk("t2_ffv", 32'(ffv_a), 1);
        chk("t2_ffx", 32'(ffx_a), 32'h2C);
        chk("t2_ffy", 32'(ffy_a), 1);
        chk("t2_pass", 32'(pass_a), 0);

        // LAT=3, failure only on the last vector
        mode_b = 3;
        start_pulse(1);
        wait_done(1, done_at, seq_err);
        chk("t3_done_at", 32'(done_at), 259);
        chk("t3_seq", 32'(seq_err), 0);
        chk("t3_fcnt", 32'(fcnt_b), 1);
        chk("t3_ffx", 32'(ffx_b), 255);
        chk("t3_ffy", 32'(ffy_b), 0);
        chk("t3_pass", 32'(pass_b), 0);

        // abort at x_o=100 after failure at 40, then resweep
        mode_a = 2;
        start_pulse(0);
        cnt = 0;
        while (x_a != 8'd100 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("t4_reach_100", 32'(x_a), 100);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("t4_busy", 32'(busy_a), 0);
        chk("t4_xvalid", 32'(xv_a), 0);
        chk("t4_fcnt", 32'(fcnt_a), 1);
        chk("t4_ffx", 32'(ffx_a), 40);
        chk("t4_pass", 32'(pass_a), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (done_a) cnt++;
            @(posedge clk); #1;
        end
        chk("t4_no_done", 32'(cnt), 0);
        mode_a = 0;
        start_pulse(0);
        chk("t4_restart_fcnt", 32'(fcnt_a), 0);
        chk("t4_restart_ffv", 32'(ffv_a), 0);
        wait_done(0, done_at, seq_err);
        chk("t4_resweep_done_at", 32'(done_at), 257);
        chk("t4_resweep_pass", 32'(pass_a), 1);

`ifdef SKOLEM_SWEEP_MISR_EN
        model_sig = '0;
        for (int x = 0; x < 256; x++)
            model_sig = {model_sig[14:0], 1'b0} ^ (model_sig[15] ? 16'hB400 : 16'h0000) ^ 16'(x & 1);
        mode_a = 4;
        exp_sig_a = model_sig;
        start_pulse(0);
        wait_done(0, done_at, seq_err);
        chk("m_sig", 32'(sig_a), 32'(model_sig));
        chk("m_pass", 32'(pass_a), 1);
        exp_sig_a = model_sig ^ 16'h0010;
        start_pulse(0);
        wait_done(0, done_at, seq_err);
        chk("m_bad_pass", 32'(pass_a), 0);
        chk("m_bad_fcnt", 32'(fcnt_a), 0);
        mode_a = 0;
`else
        model_sig = '0;
`endif

        // start_i held through DRIVE, then asynchronous reset at x_o=17
        start_a = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        chk("t5_x17", 32'(x_a), 17);
        chk("t5_busy", 32'(busy_a), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_x", 32'(x_a), 0);
        chk("t5_rst_xvalid", 32'(xv_a), 0);
        chk("t5_rst_busy", 32'(busy_a), 0);
        chk("t5_rst_done", 32'(done_a), 0);
        chk("t5_rst_pass", 32'(pass_a), 0);
        chk("t5_rst_fcnt", 32'(fcnt_a), 0);
        start_a = 1'b0;
        @(posedge clk); #1;
        chk("t5_held_in_rst", 32'(xv_a), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
